spi_master_seq: RTL
===================

// Module: spi_master_seq
// PURPOSE
//  Host-side SPI transaction sequencer for the SPI slave memory block.
//  Accepts one read/write request (7-bit addr, rw, 8-bit data) over a valid/ready handshake.
//  Generates cs_n, sclk and mosi, including the slave's turnaround sclk periods, and samples
//  miso on reads. Returns read data on a one-cycle rsp_valid pulse. No queueing: one frame at a time.
// PARAMETERS
//  DIV      2  clk cycles per sclk half-period (>=1); sclk period = 2*DIV clk
//  ADDR_W   7  address bits shifted before the rw bit
//  DATA_W   8  data bits per frame
//  TURN_WR  1  idle sclk periods between rw bit and data, write frame
//  TURN_RD  2  idle sclk periods between rw bit and data, read frame
//  CS_GAP   2  clk cycles from rsp_valid until req_ready re-asserts
// PORTS
//  clk        in   1       system clock; all logic on posedge
//  rst_n      in   1       synchronous reset, active low
//  req_valid  in   1       request present
//  req_ready  out  1       1 only in IDLE with rst_n high; accept = req_valid & req_ready
//  req_rw     in   1       1 = read, 0 = write
//  req_addr   in   ADDR_W  target address
//  req_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       1-clk pulse at frame completion
//  rsp_rdata  out  DATA_W  read data; 0 after a write; held until next rsp_valid
//  busy       out  1       1 from the cycle after accept until req_ready returns
//  sclk       out  1       SPI clock; idles low
//  cs_n       out  1       chip select, active low
//  mosi       out  1       serial out, MSB first
//  miso       in   1       serial in from slave
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge): state=IDLE; cs_n=1, sclk=0, mosi=0, rsp_valid=0,
//   rsp_rdata=0, busy=0, all counters=0; req_ready=0 while rst_n=0.
//  States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  IDLE: req_ready=1. On accept (cycle 0), capture rw/addr/wdata; later input changes are ignored.
//  SETUP: cycles 1..DIV. cs_n=0, sclk=0, mosi=addr[ADDR_W-1].
//  SHIFT: NB sclk periods, with NB = ADDR_W+1+TURN+DATA_W and TURN = rw ? TURN_RD : TURN_WR.
//   Each period is DIV clk cycles with sclk=0, then DIV clk cycles with sclk=1.
//   mosi changes only in the clk cycle where sclk falls 1->0.
//   Bit order: addr MSB..LSB, then rw, then TURN periods with mosi=0.
//   Data phase, write: wdata MSB..LSB. Data phase, read: mosi=0.
//  Read sampling: miso registered in the clk cycle sclk rises 0->1, data periods only.
//   Shifted in MSB first.
//  HOLD: DIV cycles with cs_n=0, sclk=0, mosi=0.
//  Completion cycle R = 1 + 2*DIV + 2*DIV*NB after accept. In cycle R: cs_n=1, rsp_valid=1,
//   rsp_rdata = sampled byte (read) or 0 (write).
//  GAP: cs_n=1, req_ready=0 for cycles R..R+CS_GAP-1. req_ready=1 at R+CS_GAP, so cs_n stays
//   high >= CS_GAP+1 cycles between frames.
//  req_valid while busy: ignored, never queued, never dropped silently. The requester holds
//   req_valid until accepted.
//  Reset mid-frame: next posedge with rst_n=0 aborts. cs_n=1, sclk=0, no rsp_valid for the
//   aborted frame, rsp_rdata cleared.
//  Counters: bit counter sized clog2(NB_max+1); divide counter clog2(DIV+1). Both wrap only on
//   a phase change, never free-run.
// TESTING
//  Write, DIV=2, addr=7'h15, wdata=8'hA5 -> bits at sclk rises 0010101,0,0,10100101;
//   rsp_valid at cycle 73, rdata=8'h00.
//  Read, DIV=2, addr=7'h2A, slave model drives 8'h3C -> bits 0101010,1,0,0;
//   rsp_valid at cycle 77, rdata=8'h3C.
//  req_valid held high with two queued writes -> second accept exactly CS_GAP cycles after
//   first rsp_valid; cs_n high 3 cycles in between.
//  rst_n low for 1 cycle at cycle 30 of a read -> cs_n=1, sclk=0 next cycle, no rsp_valid;
//   following write completes normally.
//  DIV=1 write -> sclk period 2 clk; rsp_valid at cycle 37.
//  Change req_addr/req_wdata right after accept -> shifted bits match captured values only.

Source files
------------

// File: rtl/spi_master_seq.sv
// SPI master transaction sequencer for the SPI slave memory block.
// Takes one read/write request, shifts out {addr, rw, turnaround, data}
// MSB first, samples miso during the read data phase, and returns a
// one-cycle rsp_valid pulse with the read byte (or zero after a write).
module spi_master_seq #(
  parameter int DIV     = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TURN_WR = 1,
  parameter int TURN_RD = 2,
  parameter int CS_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  // Frame lengths in sclk periods for each direction.
  localparam int NB_WR  = ADDR_W + 1 + TURN_WR + DATA_W;
  localparam int NB_RD  = ADDR_W + 1 + TURN_RD + DATA_W;
  localparam int NB_MAX = (NB_RD > NB_WR) ? NB_RD : NB_WR;

  localparam int BIT_W = $clog2(NB_MAX + 1);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  // Bit positions inside the left-aligned transmit frame.
  localparam int ADDR_HI = NB_MAX - 1;
  localparam int RW_POS  = NB_MAX - 1 - ADDR_W;
  localparam int WD_HI   = NB_MAX - 2 - ADDR_W - TURN_WR;

  localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST      = GAP_W'(CS_GAP - 1);
  localparam logic [BIT_W-1:0] WR_LAST       = BIT_W'(NB_WR - 1);
  localparam logic [BIT_W-1:0] RD_LAST       = BIT_W'(NB_RD - 1);
  localparam logic [BIT_W-1:0] RD_DATA_FIRST = BIT_W'(NB_RD - DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                rw_q, rw_d;
  logic                rsp_q, rsp_d;
  logic [NB_MAX-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [BIT_W-1:0]    frame_last;
  logic                accept;

  // Ready only while idle and out of reset; busy covers the whole frame and gap.
  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE);

  // Every pin is a flop output, so sclk/cs_n/mosi never glitch.
  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = tx_q[NB_MAX-1];
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;

  // Next-state and next-register logic for the frame sequencer.
  always_comb begin
    // NOTE: every target gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    rw_d       = rw_q;
    rsp_d      = 1'b0;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    frame_last = rw_q ? RD_LAST : WR_LAST;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SETUP;
          div_d   = '0;
          cs_n_d  = 1'b0;
          rw_d    = req_rw;
          rx_d    = '0;
          // Capture the whole frame now; later input changes cannot leak in.
          tx_d                      = '0;
          tx_d[ADDR_HI -: ADDR_W]   = req_addr;
          tx_d[RW_POS]              = req_rw;
          if (!req_rw) begin
            tx_d[WD_HI -: DATA_W]   = req_wdata;
          end
        end
      end

      SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = SHIFT;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising edge: sample miso only in the read data periods.
            sclk_d = 1'b1;
            if (rw_q && (bit_q >= RD_DATA_FIRST)) begin
              rx_d = {rx_q[DATA_W-2:0], miso};
            end
          end else begin
            // Falling edge: the only place mosi advances.
            sclk_d = 1'b0;
            tx_d   = {tx_q[NB_MAX-2:0], 1'b0};
            if (bit_q == frame_last) begin
              state_d = HOLD;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d = GAP;
          div_d   = '0;
          gap_d   = '0;
          cs_n_d  = 1'b1;
          rsp_d   = 1'b1;
          rdata_d = rw_q ? rx_q : '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rw_q    <= 1'b0;
      rsp_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      rw_q    <= rw_d;
      rsp_q   <= rsp_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
